// File: rtl/vfxp_writeback.sv
// Writeback stage for the vector ALU beat stream: applies vxrm rounding to
// averaging beats, buffers beats in a FWFT FIFO and drives the register file write port.
module vfxp_writeback #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BE_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned STALL_MARGIN = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_vec,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [BE_WIDTH-1:0]   in_be,
  input  logic                  in_mask,
  input  logic                  in_fxp,
  input  logic [BE_WIDTH-1:0]   in_vd,
  input  logic [BE_WIDTH-1:0]   in_vd1,
  input  logic [1:0]            cfg_sew,
  input  logic [1:0]            cfg_vxrm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_vec,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [BE_WIDTH-1:0]   out_be,
  output logic                  out_mask,
  output logic                  in_stall,
  output logic                  overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Handshake: a write is transferred on a rising edge where out_valid and
  // out_ready are both high; out_* hold stable while out_valid=1, out_ready=0.

  function automatic logic round_inc(input logic d, input logic d1, input logic [1:0] mode);
    case (mode)
      2'd0:    return d1;
      2'd1:    return d1 & d;
      2'd2:    return 1'b0;
      default: return ~d & d1;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] round_vec;

  // Each element adds its own increment within its own slice, so carries never cross elements.
  always_comb begin
    round_vec = in_vec;
    if (in_fxp && !in_mask) begin
      unique case (cfg_sew)
        2'd0: for (int j = 0; j < 8; j++)
          round_vec[8*j +: 8] = in_vec[8*j +: 8]
                                + {7'd0, round_inc(in_vd[j], in_vd1[j], cfg_vxrm)};
        2'd1: for (int j = 0; j < 4; j++)
          round_vec[16*j +: 16] = in_vec[16*j +: 16]
                                  + {15'd0, round_inc(in_vd[2*j], in_vd1[2*j], cfg_vxrm)};
        2'd2: for (int j = 0; j < 2; j++)
          round_vec[32*j +: 32] = in_vec[32*j +: 32]
                                  + {31'd0, round_inc(in_vd[4*j], in_vd1[4*j], cfg_vxrm)};
        default:
          round_vec = in_vec + {63'd0, round_inc(in_vd[0], in_vd1[0], cfg_vxrm)};
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] vec_mem  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [BE_WIDTH-1:0]   be_mem   [FIFO_DEPTH];
  logic                  mask_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q, stall_d;
  logic          overflow_q;
  logic          full, push, pop, drop;
  logic [31:0]   free_d;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = out_valid & out_ready;
  assign push    = in_valid & (~full | pop);
  assign drop    = in_valid & full & ~pop;
  assign count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  assign free_d  = 32'(FIFO_DEPTH) - 32'(count_d);
  assign stall_d = (free_d <= 32'(STALL_MARGIN));

  // Storage needs no reset: a cleared count hides every stale entry.
  always_ff @(posedge clk) begin
    if (push) begin
      vec_mem[wr_ptr_q]  <= round_vec;
      addr_mem[wr_ptr_q] <= in_addr;
      be_mem[wr_ptr_q]   <= in_be;
      mask_mem[wr_ptr_q] <= in_mask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      stall_q <= stall_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Outputs are forced to zero when empty so reset and idle show a clean port.
  assign out_valid = (count_q != '0);
  assign out_vec   = out_valid ? vec_mem[rd_ptr_q]  : '0;
  assign out_addr  = out_valid ? addr_mem[rd_ptr_q] : '0;
  assign out_be    = out_valid ? be_mem[rd_ptr_q]   : '0;
  assign out_mask  = out_valid ? mask_mem[rd_ptr_q] : 1'b0;
  assign in_stall  = stall_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_vfxp_writeback.sv
// Self-checking bench for vfxp_writeback: directed rounding/FIFO cases plus
// randomized traffic, all checked by a scoreboard against a behavioural model.
module tb_vfxp_writeback;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 6;
  localparam int W      = 64 + 32 + 8 + 1;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_vec;
  logic [31:0] in_addr;
  logic [7:0]  in_be;
  logic        in_mask;
  logic        in_fxp;
  logic [7:0]  in_vd;
  logic [7:0]  in_vd1;
  logic [1:0]  cfg_sew;
  logic [1:0]  cfg_vxrm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_vec;
  logic [31:0] out_addr;
  logic [7:0]  out_be;
  logic        out_mask;
  logic        in_stall;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_ovf   = 1'b0;
  logic         exp_stall = 1'b0;

  vfxp_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_vec    (in_vec),
    .in_addr   (in_addr),
    .in_be     (in_be),
    .in_mask   (in_mask),
    .in_fxp    (in_fxp),
    .in_vd     (in_vd),
    .in_vd1    (in_vd1),
    .cfg_sew   (cfg_sew),
    .cfg_vxrm  (cfg_vxrm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_addr  (out_addr),
    .out_be    (out_be),
    .out_mask  (out_mask),
    .in_stall  (in_stall),
    .overflow  (overflow)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference rounding: generic element loop over SEW using plain integer arithmetic.
  function automatic logic [63:0] ref_round(input logic [63:0] vec, input logic [7:0] vd,
                                            input logic [7:0] vd1, input logic [1:0] sew,
                                            input logic [1:0] vxrm, input logic fxp,
                                            input logic mask);
    longint unsigned res, elem, modm, v;
    int esz, n, idx;
    logic d, d1, r;
    if (!fxp || mask) return vec;
    esz  = 8 << sew;
    n    = 8 >> sew;
    modm = (esz == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << esz) - 64'd1);
    v    = vec;
    res  = 0;
    for (int j = 0; j < n; j++) begin
      elem = (v >> (j * esz)) & modm;
      idx  = j << sew;
      d    = vd[idx];
      d1   = vd1[idx];
      case (vxrm)
        2'd0: r = d1;
        2'd1: r = d1 & d;
        2'd2: r = 1'b0;
        default: r = ~d & d1;
      endcase
      elem = (elem + longint'(r)) & modm;
      res  = res | (elem << (j * esz));
    end
    return res;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  int           sb_sz;
  logic         sb_pop;
  logic         sb_acc;
  logic [W-1:0] sb_head;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_ovf   = 1'b0;
      exp_stall = 1'b0;
    end else begin
      sb_sz = exp_q.size();
      chk("out_valid", out_valid, sb_sz != 0);
      if (sb_sz != 0 && out_valid) begin
        sb_head = exp_q[0];
        chk("out_vec",  out_vec,  sb_head[W-1 -: 64]);
        chk("out_addr", out_addr, sb_head[40:9]);
        chk("out_be",   out_be,   sb_head[8:1]);
        chk("out_mask", out_mask, sb_head[0]);
      end
      chk("in_stall", in_stall, exp_stall);
      chk("overflow", overflow, exp_ovf);
      sb_pop = (sb_sz != 0) && out_ready;
      sb_acc = in_valid && ((sb_sz < DEPTH) || sb_pop);
      if (sb_pop) void'(exp_q.pop_front());
      if (sb_acc)
        exp_q.push_back({ref_round(in_vec, in_vd, in_vd1, cfg_sew, cfg_vxrm, in_fxp, in_mask),
                         in_addr, in_be, in_mask});
      else if (in_valid)
        exp_ovf = 1'b1;
      exp_stall = ((DEPTH - exp_q.size()) <= MARGIN);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] vec, input logic [31:0] addr, input logic [7:0] be,
                      input logic mask, input logic fxp, input logic [7:0] vd,
                      input logic [7:0] vd1);
    in_valid = 1'b1;
    in_vec   = vec;
    in_addr  = addr;
    in_be    = be;
    in_mask  = mask;
    in_fxp   = fxp;
    in_vd    = vd;
    in_vd1   = vd1;
    tick();
    in_valid = 1'b0;
  endtask

  // Beat pushed into an empty FIFO with out_ready=1 must be at the head one cycle later.
  task automatic expect_head(input string name, input logic [63:0] vec, input logic mask);
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_vec"}, out_vec, vec);
    chk({name, "_mask"}, out_mask, mask);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_vec"},   out_vec,   64'd0);
    chk({tag, "_out_addr"},  out_addr,  32'd0);
    chk({tag, "_out_be"},    out_be,    8'd0);
    chk({tag, "_out_mask"},  out_mask,  1'b0);
    chk({tag, "_in_stall"},  in_stall,  1'b0);
    chk({tag, "_overflow"},  overflow,  1'b0);
  endtask

  // ---------------- stimulus ----------------
  int n_valid;

  initial begin
    in_valid = 1'b0; in_vec = '0; in_addr = '0; in_be = '0; in_mask = 1'b0;
    in_fxp = 1'b0; in_vd = '0; in_vd1 = '0; cfg_sew = 2'd0; cfg_vxrm = 2'd0;
    out_ready = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;

    // rnu, SEW=8
    cfg_sew = 2'd0; cfg_vxrm = 2'd0;
    beat(64'h7F7F_7F7F_7F7F_7F7F, 32'h100, 8'hA5, 1'b0, 1'b1, 8'h00, 8'hFF);
    @(negedge clk);
    chk("rnu_be", out_be, 8'hA5);
    chk("rnu_vec", out_vec, 64'h8080_8080_8080_8080);
    tick();

    // mode sweep, SEW=32
    cfg_sew = 2'd2;
    cfg_vxrm = 2'd1;
    beat(64'h0000_0005_FFFF_FFFF, 32'h200, 8'hFF, 1'b0, 1'b1, 8'h11, 8'h11);
    expect_head("rne", 64'h0000_0006_0000_0000, 1'b0);
    cfg_vxrm = 2'd2;
    beat(64'h0000_0005_FFFF_FFFF, 32'h201, 8'hFF, 1'b0, 1'b1, 8'h11, 8'h11);
    expect_head("rdn", 64'h0000_0005_FFFF_FFFF, 1'b0);
    cfg_vxrm = 2'd3;
    beat(64'h0000_0005_FFFF_FFFF, 32'h202, 8'hFF, 1'b0, 1'b1, 8'h11, 8'h11);
    expect_head("rod", 64'h0000_0005_FFFF_FFFF, 1'b0);

    // passthrough on mask beats
    cfg_sew = 2'd0; cfg_vxrm = 2'd0;
    beat(64'h0123_4567_89AB_CDEF, 32'h300, 8'h0F, 1'b1, 1'b1, 8'hFF, 8'hFF);
    expect_head("pass", 64'h0123_4567_89AB_CDEF, 1'b1);

    // backpressure: fill all entries, head must stay at addr 0
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      beat({$urandom, $urandom}, i, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("bp_head_addr", out_addr, 32'd0);
      chk("bp_stall", in_stall, (i >= 1));
    end

    // full without pop: dropped; full with pop: accepted
    beat(64'hDEAD_BEEF_DEAD_BEEF, 32'd99, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("drop_overflow", overflow, 1'b1);
    chk("drop_head_addr", out_addr, 32'd0);
    out_ready = 1'b1;
    beat(64'h1111_2222_3333_4444, 32'd8, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
    n_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid) break;
      n_valid++;
    end
    chk("full_pop_drain_len", n_valid, 8);
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_vec    = {$urandom, $urandom};
      in_addr   = $urandom;
      in_be     = 8'($urandom);
      in_mask   = ($urandom_range(0, 4) == 0);
      in_fxp    = ($urandom_range(0, 2) != 0);
      in_vd     = 8'($urandom);
      in_vd1    = 8'($urandom);
      cfg_sew   = 2'($urandom_range(0, 3));
      cfg_vxrm  = 2'($urandom_range(0, 3));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++) tick();
    chk("random_drain", out_valid, 1'b0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      beat({$urandom, $urandom}, 32'h400 + i, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("pre_reset_stall", in_stall, 1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset_outputs("midreset");
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    cfg_sew = 2'd0; cfg_vxrm = 2'd2;
    beat(64'hCAFE_F00D_1234_5678, 32'd55, 8'h81, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("post_reset_valid", out_valid, 1'b1);
    chk("post_reset_addr", out_addr, 32'd55);
    tick();

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
